// File: rtl/rotator_arbiter.sv
// Arbitrates two requesters onto one shared rotator, one operation in flight at a time.
// Round-robin grant; a rotator that stays silent for TIMEOUT cycles yields an error response.
module rotator_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [DATA_W-1:0] REQ0_X,
  input  logic [DATA_W-1:0] REQ0_Y,
  input  logic [DATA_W-1:0] REQ0_ANGLE,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ1_X,
  input  logic [DATA_W-1:0] REQ1_Y,
  input  logic [DATA_W-1:0] REQ1_ANGLE,
  output logic              RSP0_VALID,
  input  logic              RSP0_READY,
  output logic [DATA_W-1:0] RSP0_X,
  output logic [DATA_W-1:0] RSP0_Y,
  output logic              RSP0_ERR,
  output logic              RSP1_VALID,
  input  logic              RSP1_READY,
  output logic [DATA_W-1:0] RSP1_X,
  output logic [DATA_W-1:0] RSP1_Y,
  output logic              RSP1_ERR,
  output logic              ROT_ENB,
  output logic [DATA_W-1:0] ROT_X,
  output logic [DATA_W-1:0] ROT_Y,
  output logic [DATA_W-1:0] ROT_ANGLE,
  input  logic [DATA_W-1:0] ROT_XOUT,
  input  logic [DATA_W-1:0] ROT_YOUT,
  input  logic              ROT_VALID,
  output logic              BUSY
);

  // state | meaning
  // IDLE  | no operation; READY offered to the requester that would win
  // ISSUE | operands presented to the rotator, timeout counter cleared
  // WAIT  | rotator enabled, waiting for ROT_VALID or timeout
  // RESP  | result held on the granted RSPn until it is consumed
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              rot_enb_q, rot_enb_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rot_x_q, rot_x_d, rot_y_q, rot_y_d, rot_a_q, rot_a_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_x_q [2];
  logic [DATA_W-1:0] rsp_x_d [2];
  logic [DATA_W-1:0] rsp_y_q [2];
  logic [DATA_W-1:0] rsp_y_d [2];
  logic              any_req, pick, xfer, rsp_ack;

  assign any_req = REQ0_VALID | REQ1_VALID;
  assign pick    = (REQ0_VALID & REQ1_VALID) ? ~last_q : REQ1_VALID;

  // READY is the only combinational output; held low while reset is asserted
  assign REQ0_READY = ARESETN & (state_q == IDLE) & any_req & ~pick;
  assign REQ1_READY = ARESETN & (state_q == IDLE) & any_req & pick;
  assign xfer       = (REQ0_VALID & REQ0_READY) | (REQ1_VALID & REQ1_READY);
  assign rsp_ack    = gnt_q ? RSP1_READY : RSP0_READY;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    rot_enb_d   = rot_enb_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    rot_x_d     = rot_x_q;
    rot_y_d     = rot_y_q;
    rot_a_d     = rot_a_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = ISSUE;
          gnt_d     = pick;
          last_d    = pick;
          rot_x_d   = pick ? REQ1_X : REQ0_X;
          rot_y_d   = pick ? REQ1_Y : REQ0_Y;
          rot_a_d   = pick ? REQ1_ANGLE : REQ0_ANGLE;
          rot_enb_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ROT_VALID) begin
          rsp_x_d[gnt_q]     = ROT_XOUT;
          rsp_y_d[gnt_q]     = ROT_YOUT;
          rsp_err_d[gnt_q]   = 1'b0;
          rsp_valid_d[gnt_q] = 1'b1;
          rot_enb_d          = 1'b0;
          state_d            = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_x_d[gnt_q]     = '0;
          rsp_y_d[gnt_q]     = '0;
          rsp_err_d[gnt_q]   = 1'b1;
          rsp_valid_d[gnt_q] = 1'b1;
          rot_enb_d          = 1'b0;
          state_d            = RESP;
        end
      end
      RESP: begin
        if (rsp_ack) begin
          rsp_valid_d = '0;
          rsp_err_d   = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      rot_enb_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      rot_x_q     <= '0;
      rot_y_q     <= '0;
      rot_a_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_x_q     <= '{default: '0};
      rsp_y_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rot_enb_q   <= rot_enb_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      rot_x_q     <= rot_x_d;
      rot_y_q     <= rot_y_d;
      rot_a_q     <= rot_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign ROT_ENB    = rot_enb_q;
  assign ROT_X      = rot_x_q;
  assign ROT_Y      = rot_y_q;
  assign ROT_ANGLE  = rot_a_q;
  assign BUSY       = busy_q;
  assign RSP0_VALID = rsp_valid_q[0];
  assign RSP1_VALID = rsp_valid_q[1];
  assign RSP0_ERR   = rsp_err_q[0];
  assign RSP1_ERR   = rsp_err_q[1];
  assign RSP0_X     = rsp_x_q[0];
  assign RSP0_Y     = rsp_y_q[0];
  assign RSP1_X     = rsp_x_q[1];
  assign RSP1_Y     = rsp_y_q[1];

endmodule

// File: tb/tb_rotator_arbiter.sv
// Bench for rotator_arbiter: the bench plays the rotator and both requesters, and predicts
// grant order, response timing and response contents from the arbitration/timeout rules.
module tb_rotator_arbiter;
  localparam int TMO = 64;

  logic       ACLK, ARESETN;
  logic       REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [7:0] REQ0_X, REQ0_Y, REQ0_ANGLE, REQ1_X, REQ1_Y, REQ1_ANGLE;
  logic       RSP0_VALID, RSP0_READY, RSP0_ERR, RSP1_VALID, RSP1_READY, RSP1_ERR;
  logic [7:0] RSP0_X, RSP0_Y, RSP1_X, RSP1_Y;
  logic       ROT_ENB, ROT_VALID, BUSY;
  logic [7:0] ROT_X, ROT_Y, ROT_ANGLE, ROT_XOUT, ROT_YOUT;

  int total = 0;
  int bad   = 0;
  int last  = 1;
  logic [7:0] opx [2];
  logic [7:0] opy [2];
  logic [7:0] opa [2];
  logic [7:0] rx, ry;

  rotator_arbiter #(.DATA_W(8), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_X(REQ0_X), .REQ0_Y(REQ0_Y),
    .REQ0_ANGLE(REQ0_ANGLE),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_X(REQ1_X), .REQ1_Y(REQ1_Y),
    .REQ1_ANGLE(REQ1_ANGLE),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_X(RSP0_X), .RSP0_Y(RSP0_Y),
    .RSP0_ERR(RSP0_ERR),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_X(RSP1_X), .RSP1_Y(RSP1_Y),
    .RSP1_ERR(RSP1_ERR),
    .ROT_ENB(ROT_ENB), .ROT_X(ROT_X), .ROT_Y(ROT_Y), .ROT_ANGLE(ROT_ANGLE),
    .ROT_XOUT(ROT_XOUT), .ROT_YOUT(ROT_YOUT), .ROT_VALID(ROT_VALID), .BUSY(BUSY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic get_rsp(input int g, output logic v, output logic [7:0] x, output logic [7:0] y,
                         output logic e);
    v = (g == 1) ? RSP1_VALID : RSP0_VALID;
    x = (g == 1) ? RSP1_X : RSP0_X;
    y = (g == 1) ? RSP1_Y : RSP0_Y;
    e = (g == 1) ? RSP1_ERR : RSP0_ERR;
  endtask

  task automatic scramble_reqs();
    REQ0_VALID = 1'($urandom_range(0, 1));
    REQ1_VALID = 1'($urandom_range(0, 1));
    REQ0_X = 8'($urandom); REQ0_Y = 8'($urandom); REQ0_ANGLE = 8'($urandom);
    REQ1_X = 8'($urandom); REQ1_Y = 8'($urandom); REQ1_ANGLE = 8'($urandom);
  endtask

  // Called at a falling edge with the arbiter idle. d = WAIT cycle (0-based) on which the
  // rotator answers; d >= TMO means it never does. hold = cycles RSP_READY is withheld.
  task automatic do_op(input bit v0, input bit v1, input int d, input int hold);
    int g, lat;
    logic [7:0] ex, ey, ea, exp_x, exp_y, gx, gy;
    logic exp_err, gv, ge;
    REQ0_VALID = v0; REQ1_VALID = v1;
    REQ0_X = opx[0]; REQ0_Y = opy[0]; REQ0_ANGLE = opa[0];
    REQ1_X = opx[1]; REQ1_Y = opy[1]; REQ1_ANGLE = opa[1];
    ROT_VALID = 1'($urandom_range(0, 1));
    ROT_XOUT = 8'($urandom); ROT_YOUT = 8'($urandom);
    g = (v0 && v1) ? 1 - last : (v0 ? 0 : 1);
    #1;
    check("ready0_idle", 32'(REQ0_READY), 32'(g == 0));
    check("ready1_idle", 32'(REQ1_READY), 32'(g == 1));
    check("busy_idle", 32'(BUSY), 0);
    check("enb_idle", 32'(ROT_ENB), 0);
    ex = opx[g]; ey = opy[g]; ea = opa[g];
    last = g;
    if (d < TMO) begin
      lat = d + 3; exp_x = rx; exp_y = ry; exp_err = 1'b0;
    end else begin
      lat = TMO + 2; exp_x = 8'h00; exp_y = 8'h00; exp_err = 1'b1;
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge ACLK);
      check("enb_op", 32'(ROT_ENB), 32'(c < lat));
      check("busy_op", 32'(BUSY), 1);
      check("rsp0_valid_op", 32'(RSP0_VALID), 32'(c == lat && g == 0));
      check("rsp1_valid_op", 32'(RSP1_VALID), 32'(c == lat && g == 1));
      if (c < lat) begin
        check("rot_x", 32'(ROT_X), 32'(ex));
        check("rot_y", 32'(ROT_Y), 32'(ey));
        check("rot_angle", 32'(ROT_ANGLE), 32'(ea));
      end
      scramble_reqs();
      if (c == d + 2) begin
        ROT_VALID = 1'b1; ROT_XOUT = rx; ROT_YOUT = ry;
      end else begin
        ROT_VALID = (c == 1 || c >= lat) ? 1'($urandom_range(0, 1)) : 1'b0;
        ROT_XOUT = 8'($urandom); ROT_YOUT = 8'($urandom);
      end
      #1;
      check("ready0_op", 32'(REQ0_READY), 0);
      check("ready1_op", 32'(REQ1_READY), 0);
    end
    get_rsp(g, gv, gx, gy, ge);
    check("rsp_x", 32'(gx), 32'(exp_x));
    check("rsp_y", 32'(gy), 32'(exp_y));
    check("rsp_err", 32'(ge), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      REQ0_VALID = 1'b1; REQ1_VALID = 1'($urandom_range(0, 1));
      RSP0_READY = (g == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      RSP1_READY = (g == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      ROT_VALID = 1'($urandom_range(0, 1)); ROT_XOUT = 8'($urandom); ROT_YOUT = 8'($urandom);
      #1;
      check("ready0_hold", 32'(REQ0_READY), 0);
      check("ready1_hold", 32'(REQ1_READY), 0);
      @(negedge ACLK);
      get_rsp(g, gv, gx, gy, ge);
      check("hold_valid", 32'(gv), 1);
      check("hold_x", 32'(gx), 32'(exp_x));
      check("hold_y", 32'(gy), 32'(exp_y));
      check("hold_err", 32'(ge), 32'(exp_err));
      get_rsp(1 - g, gv, gx, gy, ge);
      check("hold_other_valid", 32'(gv), 0);
      check("hold_busy", 32'(BUSY), 1);
      check("hold_enb", 32'(ROT_ENB), 0);
    end
    RSP0_READY = (g == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    RSP1_READY = (g == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    check("ready0_ack", 32'(REQ0_READY), 0);
    check("ready1_ack", 32'(REQ1_READY), 0);
    @(negedge ACLK);
    check("done_rsp0_valid", 32'(RSP0_VALID), 0);
    check("done_rsp1_valid", 32'(RSP1_VALID), 0);
    check("done_busy", 32'(BUSY), 0);
    check("done_enb", 32'(ROT_ENB), 0);
    RSP0_READY = 1'b0; RSP1_READY = 1'b0;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < 2; i++) begin
      opx[i] = 8'($urandom); opy[i] = 8'($urandom); opa[i] = 8'($urandom);
    end
    rx = 8'($urandom); ry = 8'($urandom);
  endtask

  initial begin
    int p, gap;
    ARESETN = 1'b0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    REQ0_X = 8'h0; REQ0_Y = 8'h0; REQ0_ANGLE = 8'h0;
    REQ1_X = 8'h0; REQ1_Y = 8'h0; REQ1_ANGLE = 8'h0;
    RSP0_READY = 1'b0; RSP1_READY = 1'b0;
    ROT_VALID = 1'b1; ROT_XOUT = 8'h55; ROT_YOUT = 8'hAA;
    repeat (3) @(negedge ACLK);
    check("rst_ready0", 32'(REQ0_READY), 0);
    check("rst_ready1", 32'(REQ1_READY), 0);
    check("rst_rsp", 32'({RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR}), 0);
    check("rst_enb_busy", 32'({ROT_ENB, BUSY}), 0);
    check("rst_rot", 32'({ROT_X, ROT_Y, ROT_ANGLE}), 0);
    check("rst_rsp_xy", {RSP0_X, RSP0_Y, RSP1_X, RSP1_Y}, 0);
    ARESETN = 1'b1;

    // contention straight out of reset: expected 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      rand_operands();
      do_op(1'b1, 1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
      check("contention_order", 32'(last), 32'(i % 2));
    end

    opx[0] = 8'h20; opy[0] = 8'h10; opa[0] = 8'h40; rx = 8'h12; ry = 8'h34;
    opx[1] = 8'hEE; opy[1] = 8'hDD; opa[1] = 8'hCC;
    do_op(1'b1, 1'b0, 0, 0);

    rand_operands();
    do_op(1'b1, 1'b0, 1000, 3);

    rand_operands();
    do_op(1'b0, 1'b1, 5, 10);

    for (int i = 0; i < 20; i++) begin
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; ROT_VALID = 1'($urandom_range(0, 1));
        #1;
        check("ready_none", 32'({REQ0_READY, REQ1_READY}), 0);
        @(negedge ACLK);
        check("busy_none", 32'(BUSY), 0);
      end
      rand_operands();
      p = int'($urandom_range(1, 3));
      do_op(p[0], p[1], int'($urandom_range(0, 70)), int'($urandom_range(0, 3)));
    end

    // reset while waiting on the rotator
    rand_operands();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b1; ROT_VALID = 1'b0;
    REQ1_X = opx[1]; REQ1_Y = opy[1]; REQ1_ANGLE = opa[1];
    #1;
    check("rw_ready1", 32'(REQ1_READY), 1);
    @(negedge ACLK);
    REQ1_VALID = 1'b0;
    @(negedge ACLK);
    check("rw_enb_wait", 32'(ROT_ENB), 1);
    ARESETN = 1'b0; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    ROT_VALID = 1'b1; ROT_XOUT = 8'h77; ROT_YOUT = 8'h66;
    #1;
    check("rw_ready", 32'({REQ0_READY, REQ1_READY}), 0);
    check("rw_rsp", 32'({RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR}), 0);
    check("rw_enb_busy", 32'({ROT_ENB, BUSY}), 0);
    check("rw_rot", 32'({ROT_X, ROT_Y, ROT_ANGLE}), 0);
    check("rw_rsp_xy", {RSP0_X, RSP0_Y, RSP1_X, RSP1_Y}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    for (int k = 0; k < TMO + 6; k++) begin
      ROT_VALID = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      check("rw_no_rsp", 32'({RSP0_VALID, RSP1_VALID, BUSY}), 0);
    end
    last = 1;
    rand_operands();
    do_op(1'b1, 1'b1, 2, 1);
    check("rw_ptr_reset", 32'(last), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
